// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and key identifier for the PS/2 Set-2 scancode decoder.
package ps2_pkg;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BRK   = 8'hF0;
    localparam logic [7:0] PREFIX_PAUSE = 8'hE1;
    localparam logic [7:0] BAT_OK       = 8'hAA;
    localparam logic [7:0] ACK          = 8'hFA;
    localparam logic [7:0] RESEND       = 8'hFE;
    localparam logic [7:0] ECHO         = 8'hEE;

    localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_id_t;

    // Keyboard housekeeping replies and error bytes never represent a key.
    function automatic logic is_drop(input logic [7:0] b);
        return (b == BAT_OK) || (b == ACK) || (b == RESEND) || (b == ECHO) ||
               (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational Set-2 make code to lowercase ASCII lookup; unmapped codes give 8'h00.
module ps2_scan2ascii (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 Set-2 prefix sequences into single key events with ASCII, held-key and make count.
// Optional: define PS2_REPEAT_FILTER_EN to suppress typematic repeats of the held key.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic [7:0]       key_ascii,
    output logic             key_held,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] make_cnt,
    output logic             seq_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       pause_cnt;
    logic             timeout;
    logic             emit_make, emit_break, emit_ext;
    logic             make_ok, is_repeat;
    logic [7:0]       ascii;
    key_id_t          ev_id;

    assign timeout = (state != ST_IDLE) && !byte_valid &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if      (byte_in == PREFIX_EXT)   state_nxt = ST_EXT;
                    else if (byte_in == PREFIX_BRK)   state_nxt = ST_BRK;
                    else if (byte_in == PREFIX_PAUSE) state_nxt = ST_PAUSE;
                end
                ST_EXT: begin
                    if      (byte_in == PREFIX_BRK) state_nxt = ST_EXT_BRK;
                    else if (byte_in != PREFIX_EXT) state_nxt = ST_IDLE;
                end
                ST_BRK: begin
                    if      (byte_in == PREFIX_EXT) state_nxt = ST_EXT_BRK;
                    else if (byte_in != PREFIX_BRK) state_nxt = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    if (byte_in != PREFIX_EXT && byte_in != PREFIX_BRK) state_nxt = ST_IDLE;
                end
                ST_PAUSE: begin
                    if (pause_cnt <= 3'd1) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        if (timeout) state_nxt = ST_IDLE;
    end

    always_comb begin
        emit_make  = 1'b0;
        emit_break = 1'b0;
        emit_ext   = 1'b0;
        if (byte_valid) begin
            case (state)
                ST_IDLE: emit_make = (byte_in != PREFIX_EXT) && (byte_in != PREFIX_BRK) &&
                                     (byte_in != PREFIX_PAUSE) && !is_drop(byte_in);
                ST_EXT: begin
                    emit_make = (byte_in != PREFIX_EXT) && (byte_in != PREFIX_BRK);
                    emit_ext  = 1'b1;
                end
                ST_BRK:  emit_break = (byte_in != PREFIX_EXT) && (byte_in != PREFIX_BRK);
                ST_EXT_BRK: begin
                    emit_break = (byte_in != PREFIX_EXT) && (byte_in != PREFIX_BRK);
                    emit_ext   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ev_id     = '{ext: emit_ext, code: byte_in};
    assign is_repeat = key_held && (held_code == ev_id);

`ifdef PS2_REPEAT_FILTER_EN
    assign make_ok = emit_make && !is_repeat;
`else
    assign make_ok = emit_make;
`endif

    ps2_scan2ascii u_scan2ascii (
        .code  (byte_in),
        .ascii (ascii)
    );

    // Prefix watchdog: only runs while a sequence is open, any byte restarts it.
    always_ff @(posedge clk) begin
        if (rst || byte_valid || state == ST_IDLE || timeout) tmo_cnt <= '0;
        else                                                  tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || timeout)
            pause_cnt <= '0;
        else if (byte_valid && state == ST_IDLE && byte_in == PREFIX_PAUSE)
            pause_cnt <= PAUSE_TAIL_LEN;
        else if (byte_valid && state == ST_PAUSE && pause_cnt != 3'd0)
            pause_cnt <= pause_cnt - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_ascii   <= '0;
            key_held    <= 1'b0;
            held_code   <= '0;
            make_cnt    <= '0;
            seq_err     <= 1'b0;
        end else begin
            key_valid <= make_ok || emit_break;
            seq_err   <= timeout;
            if (make_ok || emit_break) begin
                key_code    <= byte_in;
                key_ext     <= emit_ext;
                key_release <= emit_break;
                key_ascii   <= emit_ext ? 8'h00 : ascii;
            end
            if (make_ok) begin
                key_held  <= 1'b1;
                held_code <= ev_id;
                make_cnt  <= make_cnt + CNT_W'(1);
            end else if (emit_break && held_code == ev_id) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomized bench for ps2_scancode_decoder against a byte-stream reference model.
module tb_ps2_scancode_decoder;

    localparam int TMO   = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       byte_in = 8'h00;
    logic             byte_valid = 1'b0;
    logic             key_valid, key_ext, key_release, key_held, seq_err;
    logic [7:0]       key_code, key_ascii;
    logic [8:0]       held_code;
    logic [CNT_W-1:0] make_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_release(key_release), .key_ascii(key_ascii), .key_held(key_held),
        .held_code(held_code), .make_cnt(make_cnt), .seq_err(seq_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] to_ascii(input logic [7:0] b);
        logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
        logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
        for (int i = 0; i < 26; i++) if (letters[i] == b) return 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) if (digits[i] == b) return 8'h30 + 8'(i);
        if (b == 8'h29) return 8'h20;
        if (b == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    // Reference model: pending prefix flags, remaining pause bytes, stall length.
    logic       m_ext, m_brk, m_valid, m_err, m_kext, m_rel, m_held;
    int         m_pause, m_stall;
    logic [7:0] m_code, m_ascii;
    logic [8:0] m_hcode;
    int         m_cnt;

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_pause = 0; m_stall = 0;
        m_valid = 0; m_err = 0; m_kext = 0; m_rel = 0; m_held = 0;
        m_code = 0; m_ascii = 0; m_hcode = 0; m_cnt = 0;
    endtask

    task automatic emit(input logic ext, input logic brk, input logic [7:0] b);
        logic rep;
        rep = m_held && (m_hcode == {ext, b});
`ifdef PS2_REPEAT_FILTER_EN
        if (!brk && rep) return;
`endif
        m_valid = 1; m_code = b; m_kext = ext; m_rel = brk;
        m_ascii = ext ? 8'h00 : to_ascii(b);
        if (!brk) begin
            m_held = 1; m_hcode = {ext, b}; m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end else if (m_hcode == {ext, b}) begin
            m_held = 0;
        end
    endtask

    task automatic model_step(input logic r, input logic bv, input logic [7:0] b);
        logic idle;
        if (r) begin model_reset(); return; end
        m_valid = 0; m_err = 0;
        idle = !m_ext && !m_brk && m_pause == 0;
        if (bv) begin
            m_stall = 0;
            if (m_pause > 0) m_pause--;
            else if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (idle && b == 8'hE1) m_pause = 7;
            else if (idle && (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE ||
                              b == 8'h00 || b == 8'hFF)) ;
            else begin
                emit(m_ext, m_brk, b);
                m_ext = 0; m_brk = 0;
            end
        end else if (!idle) begin
            m_stall++;
            if (m_stall == TMO) begin
                m_err = 1; m_ext = 0; m_brk = 0; m_pause = 0; m_stall = 0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            logic       s_r, s_bv;
            logic [7:0] s_b;
            @(posedge clk);
            s_r = rst; s_bv = byte_valid; s_b = byte_in;
            model_step(s_r, s_bv, s_b);
            #1;
            chk("key_valid", key_valid, m_valid);
            chk("seq_err", seq_err, m_err);
            chk("key_held", key_held, m_held);
            chk("held_code", held_code, m_hcode);
            chk("make_cnt", make_cnt, m_cnt);
            chk("key_code", key_code, m_code);
            chk("key_ext", key_ext, m_kext);
            chk("key_release", key_release, m_rel);
            chk("key_ascii", key_ascii, m_ascii);
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        byte_in = b; byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; byte_in = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] s [], input int gap);
        foreach (s[i]) send(s[i], gap);
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] keys [12] = '{8'h1C, 8'h32, 8'h29, 8'h5A, 8'h45, 8'h46, 8'h1A,
                                  8'h75, 8'h6B, 8'h14, 8'h11, 8'h77};
        logic [7:0] drops [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
        int p;
        p = $urandom_range(99);
        if (p < 45) return keys[$urandom_range(11)];
        if (p < 60) return 8'hE0;
        if (p < 75) return 8'hF0;
        if (p < 78) return 8'hE1;
        if (p < 85) return drops[$urandom_range(5)];
        return 8'($urandom);
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_seq('{8'h1C}, 2);
        send_seq('{8'hF0, 8'h1C}, 1);
        send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}, 0);
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29}, 1);
        send_seq('{8'hAA, 8'hFA}, 1);
        send(8'hE0, TMO + 4);
        send(8'h1C, 2);
        send(8'hE0, TMO - 2);
        send(8'h6B, 2);
        send(8'hF0, 0);
        pulse_rst();
        send(8'h1C, 2);
        send_seq('{8'h1C, 8'h1C, 8'h1C}, 0);
        for (int i = 0; i < 256; i++) send((i % 2) ? 8'h32 : 8'h1C, 0);
        for (int i = 0; i < 3000; i++) begin
            int g;
            g = ($urandom_range(99) < 4) ? TMO + $urandom_range(3) - 1 : $urandom_range(2);
            if ($urandom_range(199) == 0) pulse_rst();
            send(rand_byte(), g);
        end
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
